channel_fir_multi: RTL

- Symbol-rate discrete-time channel emulator for the high-speed link testbench.
- Models inter-symbol interference as a programmable FIR pulse response, with NUM_CH independent lanes.
- Sits between the TX symbol generator and the RX sampler/equalizer models in clocked link benches.
- Tap sets are loaded through a shadow bank and committed atomically on a symbol boundary, so live traffic never sees a partially written response.

---
 rtl/channel_fir_multi.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/channel_fir_multi.sv
// channel_fir_multi
// Symbol-rate discrete-time channel emulator. Each of NUM_CH lanes runs an
// independent NUM_TAP-tap FIR pulse response (tap 0 is the cursor), so the
// TX symbol stream picks up inter-symbol interference before it reaches the
// RX sampler model. Coefficients are written into a shadow bank and swapped
// into the active bank on the first symbol strobe after a commit request.
// That symbol still uses the old taps, and the next one uses the new taps.
//
// Optional feature macro: CHANNEL_XTALK_EN
//   When defined, each lane k also holds a crosstalk coefficient xt[k]
//   (written with cfg_tap == NUM_TAP). The term xt[k] * sym[(k+1) mod NUM_CH]
//   is added to lane k, and OUT_W grows by one bit.
//
// Ports
//   clk        in   symbol-rate clock
//   rst        in   synchronous reset, active-high
//   in_valid   in   symbol strobe, one new symbol per lane
//   in_sym     in   lane symbols, lane k at [k*SYM_W +: SYM_W], signed
//   out_valid  out  output sample strobe, 2 cycles after in_valid
//   out_sample out  lane outputs, lane k at [k*OUT_W +: OUT_W], signed
//   cfg_valid  in   coefficient write request
//   cfg_ready  out  coefficient write accept (low while a commit is pending)
//   cfg_ch     in   target lane
//   cfg_tap    in   target tap index
//   cfg_coef   in   coefficient value, Q(COEF_W-2)
//   cfg_commit in   request shadow-to-active swap
module channel_fir_multi #(
  parameter int NUM_CH  = 2,
  parameter int NUM_TAP = 8,
  parameter int SYM_W   = 3,
  parameter int COEF_W  = 12,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int TAP_W  = $clog2(NUM_TAP + 1),
`ifdef CHANNEL_XTALK_EN
  localparam int OUT_W  = SYM_W + COEF_W + $clog2(NUM_TAP) + 1
`else
  localparam int OUT_W  = SYM_W + COEF_W + $clog2(NUM_TAP)
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [NUM_CH*SYM_W-1:0]  in_sym,
  output logic                     out_valid,
  output logic [NUM_CH*OUT_W-1:0]  out_sample,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [CH_W-1:0]          cfg_ch,
  input  logic [TAP_W-1:0]         cfg_tap,
  input  logic [COEF_W-1:0]        cfg_coef,
  input  logic                     cfg_commit
);

  localparam int PROD_W = SYM_W + COEF_W;

  typedef logic signed [SYM_W-1:0]  sym_t;
  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic signed [PROD_W-1:0] prod_t;
  typedef enum logic {IDLE, PEND} state_t;

  localparam coef_t UNITY = {2'b01, {(COEF_W-2){1'b0}}};

  state_t state_q, state_d;
  logic   commit;

  coef_t rst_bank [NUM_CH][NUM_TAP];
  coef_t shadow_q [NUM_CH][NUM_TAP];
  coef_t shadow_d [NUM_CH][NUM_TAP];
  coef_t active_q [NUM_CH][NUM_TAP];
  coef_t active_d [NUM_CH][NUM_TAP];

  sym_t  win    [NUM_CH][NUM_TAP];
  sym_t  hist_q [NUM_CH][NUM_TAP-1];
  sym_t  hist_d [NUM_CH][NUM_TAP-1];
  prod_t prod_q [NUM_CH][NUM_TAP];
  prod_t prod_d [NUM_CH][NUM_TAP];

  logic                       valid1_q;
  logic                       valid2_q;
  logic signed [OUT_W-1:0]    sum_d [NUM_CH];
  logic [NUM_CH*OUT_W-1:0]    out_q;
  logic [NUM_CH*OUT_W-1:0]    out_d;

`ifdef CHANNEL_XTALK_EN
  coef_t xt_shadow_q [NUM_CH];
  coef_t xt_shadow_d [NUM_CH];
  coef_t xt_active_q [NUM_CH];
  coef_t xt_active_d [NUM_CH];
  prod_t xt_prod_q   [NUM_CH];
  prod_t xt_prod_d   [NUM_CH];
`endif

  // Commit handshake. A commit request parks the FSM in PEND with writes
  // blocked. The swap happens on the next symbol edge, so a lane never
  // switches banks partway through a symbol.
  always_comb begin
    state_d   = state_q;
    cfg_ready = 1'b0;
    commit    = 1'b0;
    case (state_q)
      IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_commit) state_d = PEND;
      end
      PEND: begin
        if (in_valid) begin
          commit  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Identity channel used as the reset image of both banks.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      for (int t = 0; t < NUM_TAP; t++) begin
        rst_bank[c][t] = (t == 0) ? UNITY : '0;
      end
    end
  end

  // Shadow writes decode lane and tap by comparison, so indices outside the
  // bank simply match nothing and the write is dropped.
  // The active bank copies the whole shadow bank on commit.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
`ifdef CHANNEL_XTALK_EN
    xt_shadow_d = xt_shadow_q;
    xt_active_d = xt_active_q;
`endif
    if (cfg_valid && cfg_ready) begin
      for (int c = 0; c < NUM_CH; c++) begin
        for (int t = 0; t < NUM_TAP; t++) begin
          if (int'(cfg_ch) == c && int'(cfg_tap) == t) shadow_d[c][t] = cfg_coef;
        end
`ifdef CHANNEL_XTALK_EN
        if (int'(cfg_ch) == c && int'(cfg_tap) == NUM_TAP) xt_shadow_d[c] = cfg_coef;
`endif
      end
    end
    if (commit) begin
      active_d = shadow_q;
`ifdef CHANNEL_XTALK_EN
      xt_active_d = xt_shadow_q;
`endif
    end
  end

  // The FIR window is the incoming symbol plus the stored history.
  // Products are formed from the bank as it stands before this edge. On a
  // commit edge, the committing symbol therefore still sees the old taps.
  // History only advances on a strobe, so idle cycles do not age the channel.
  always_comb begin
    hist_d = hist_q;
    for (int c = 0; c < NUM_CH; c++) begin
      win[c][0] = sym_t'(in_sym[c*SYM_W +: SYM_W]);
      for (int t = 1; t < NUM_TAP; t++) begin
        win[c][t] = hist_q[c][t-1];
      end
      for (int t = 0; t < NUM_TAP; t++) begin
        prod_d[c][t] = prod_t'(win[c][t]) * prod_t'(active_q[c][t]);
      end
      if (in_valid) begin
        for (int t = 0; t < NUM_TAP-1; t++) begin
          hist_d[c][t] = win[c][t];
        end
      end
    end
`ifdef CHANNEL_XTALK_EN
    for (int c = 0; c < NUM_CH; c++) begin
      xt_prod_d[c] = prod_t'(win[(c+1) % NUM_CH][0]) * prod_t'(xt_active_q[c]);
    end
`endif
  end

  // Second pipeline stage. Registered products are summed at full width,
  // and the result is held in the output register until the next strobe.
  always_comb begin
    out_d = out_q;
    for (int c = 0; c < NUM_CH; c++) begin
      sum_d[c] = '0;
      for (int t = 0; t < NUM_TAP; t++) begin
        sum_d[c] = sum_d[c] + OUT_W'(prod_q[c][t]);
      end
`ifdef CHANNEL_XTALK_EN
      sum_d[c] = sum_d[c] + OUT_W'(xt_prod_q[c]);
`endif
      if (valid1_q) out_d[c*OUT_W +: OUT_W] = sum_d[c];
    end
  end

  // State registers. Reset flushes the pipeline valid bits, so symbols
  // accepted before reset never produce an output strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      shadow_q <= rst_bank;
      active_q <= rst_bank;
      hist_q   <= '{default: '0};
      prod_q   <= '{default: '0};
      valid1_q <= 1'b0;
      valid2_q <= 1'b0;
      out_q    <= '0;
`ifdef CHANNEL_XTALK_EN
      xt_shadow_q <= '{default: '0};
      xt_active_q <= '{default: '0};
      xt_prod_q   <= '{default: '0};
`endif
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      hist_q   <= hist_d;
      valid1_q <= in_valid;
      valid2_q <= valid1_q;
      out_q    <= out_d;
      if (in_valid) prod_q <= prod_d;
`ifdef CHANNEL_XTALK_EN
      xt_shadow_q <= xt_shadow_d;
      xt_active_q <= xt_active_d;
      if (in_valid) xt_prod_q <= xt_prod_d;
`endif
    end
  end

  assign out_valid  = valid2_q;
  assign out_sample = out_q;

endmodule
